// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory store/load, UART pop, write-back select.
module mem_access_stage #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_MEM_WIDTH = 16,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic [31:0]               register_data,
  input  logic [31:0]               alu_result,
  input  logic [4:0]                rdist,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      stall,
  output logic [DATA_MEM_WIDTH-1:0] dmem_addr,
  output logic [31:0]               dmem_wdata,
  output logic                      dmem_we,
  input  logic [31:0]               dmem_rdata,
  input  logic                      uart_rx_valid,
  input  logic [7:0]                uart_rx_data,
  output logic                      uart_rx_ready,
  output logic                      wb_valid,
  output logic                      RegWrite_wb,
  output logic [4:0]                rdist_wb,
  output logic [31:0]               wb_data
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, UART_WAIT} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [DATA_MEM_WIDTH-1:0] addr_q, addr_nxt;
  logic                      accept;
  logic                      op_uart, op_load, op_store;
  logic [31:0]               wb_sel;

  // UART pop outranks load, load outranks store
  assign op_uart  = UARTtoReg;
  assign op_load  = MemRead & ~UARTtoReg;
  assign op_store = MemWrite & ~MemRead & ~UARTtoReg;

  assign dmem_wdata = register_data;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    addr_nxt      = addr_q;
    stall         = 1'b0;
    accept        = 1'b0;
    dmem_we       = 1'b0;
    uart_rx_ready = 1'b0;
    dmem_addr     = alu_result[DATA_MEM_WIDTH-1:0];
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (op_uart) begin
            if (uart_rx_valid) begin
              uart_rx_ready = 1'b1;
              accept        = 1'b1;
            end else begin
              stall     = 1'b1;
              state_nxt = UART_WAIT;
            end
          end else if (op_load) begin
            stall     = 1'b1;
            addr_nxt  = alu_result[DATA_MEM_WIDTH-1:0];
            cnt_nxt   = CW'(MEM_LATENCY - 1);
            state_nxt = MEM_WAIT;
          end else begin
            accept  = 1'b1;
            dmem_we = op_store;
          end
        end
      end
      MEM_WAIT: begin
        dmem_addr = addr_q;
        if (cnt != '0) begin
          stall   = 1'b1;
          cnt_nxt = cnt - CW'(1);
        end else begin
          accept    = in_valid;
          state_nxt = IDLE;
        end
      end
      UART_WAIT: begin
        if (!in_valid) begin
          state_nxt = IDLE;
        end else if (uart_rx_valid) begin
          uart_rx_ready = 1'b1;
          accept        = 1'b1;
          state_nxt     = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs forced quiet while reset is asserted, independent of the clock
    if (reset) begin
      stall         = 1'b0;
      accept        = 1'b0;
      dmem_we       = 1'b0;
      uart_rx_ready = 1'b0;
    end
  end

  always_comb begin
    wb_sel = alu_result;
    if (op_uart) begin
      wb_sel = {24'b0, uart_rx_data};
    end else begin
      case (MemtoReg)
        2'b00:   wb_sel = alu_result;
        2'b01:   wb_sel = dmem_rdata;
        2'b10:   wb_sel = {{(32-INST_MEM_WIDTH){1'b0}}, pc1};
        default: wb_sel = register_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wb_valid    <= 1'b0;
      RegWrite_wb <= 1'b0;
      rdist_wb    <= '0;
      wb_data     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      if (accept) begin
        wb_valid    <= 1'b1;
        RegWrite_wb <= RegWrite;
        rdist_wb    <= rdist;
        wb_data     <= wb_sel;
      end else begin
        wb_valid    <= 1'b0;
        RegWrite_wb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with RAM model and WB scoreboard.
module tb_mem_access_stage;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, RegWrite, MemWrite, MemRead, UARTtoReg;
  logic [1:0]  MemtoReg;
  logic [31:0] register_data, alu_result;
  logic [4:0]  rdist;
  logic [1:0]  pc1;
  logic        stall, dmem_we, uart_rx_valid, uart_rx_ready;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata, wb_data;
  logic [7:0]  uart_rx_data;
  logic        wb_valid, RegWrite_wb;
  logic [4:0]  rdist_wb;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int ready_cnt = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.INST_MEM_WIDTH(2), .DATA_MEM_WIDTH(16), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .MemRead(MemRead), .UARTtoReg(UARTtoReg),
    .register_data(register_data), .alu_result(alu_result), .rdist(rdist), .pc1(pc1),
    .stall(stall), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_ready(uart_rx_ready), .wb_valid(wb_valid), .RegWrite_wb(RegWrite_wb),
    .rdist_wb(rdist_wb), .wb_data(wb_data)
  );

  // RAM model: address pipeline of L stages, read data valid L cycles after address
  logic [31:0] mem [0:255];
  logic [15:0] apipe [0:L-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      for (int i = 0; i < L; i++) apipe[i] <= '0;
    end else begin
      if (dmem_we) mem[dmem_addr[7:0]] <= dmem_wdata;
      apipe[0] <= dmem_addr;
      for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign dmem_rdata = mem[apipe[L-1][7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sbq[$];

  always @(negedge clk) begin : mon
    wb_t e;
    if (!reset) begin
      if (dmem_we) we_cnt++;
      if (uart_rx_ready) begin
        ready_cnt++;
        chk("ready_without_valid", {31'b0, uart_rx_valid}, 32'd1);
      end
      if (wb_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_wb_valid", {31'b0, wb_valid}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("rdist_wb", {27'b0, rdist_wb}, {27'b0, e.rd});
          chk("RegWrite_wb", {31'b0, RegWrite_wb}, {31'b0, e.rw});
        end
      end
    end
  end

  typedef struct {
    logic        rw;
    logic [1:0]  mt;
    logic        mw, mr, ut;
    logic [31:0] rdata, alu;
    logic [4:0]  rd;
    logic [1:0]  pc;
    logic        rxv;
    logic [7:0]  rxd;
    int          exp_stall;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  task automatic drive(input vec_t v);
    in_valid = 1'b1; RegWrite = v.rw; MemtoReg = v.mt; MemWrite = v.mw; MemRead = v.mr;
    UARTtoReg = v.ut; register_data = v.rdata; alu_result = v.alu; rdist = v.rd; pc1 = v.pc;
    uart_rx_valid = v.rxv; uart_rx_data = v.rxd;
  endtask

  // Entered and left at posedge+1; raises uart_rx_valid with byte rx_late after late_at stall cycles
  task automatic run_vec(input vec_t v, input string nm, input int late_at, input logic [7:0] rx_late);
    int   sc = 0;
    logic done = 1'b0;
    wb_t  e;
    drive(v);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        sc++;
        chk({nm, "_we_in_stall"}, {31'b0, dmem_we}, 32'd0);
      end else begin
        done = 1'b1;
        chk({nm, "_we"}, {31'b0, dmem_we}, {31'b0, v.exp_we});
        if (v.exp_we) chk({nm, "_addr"}, {16'b0, dmem_addr}, {16'b0, v.alu[15:0]});
        chk({nm, "_ready"}, {31'b0, uart_rx_ready}, {31'b0, v.ut});
        e.rw = v.rw; e.rd = v.rd; e.data = v.exp_data;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      if (late_at >= 0 && sc == late_at) begin
        uart_rx_valid = 1'b1;
        uart_rx_data  = rx_late;
      end
    end
    if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
    chk({nm, "_stall_cycles"}, 32'(sc), 32'(v.exp_stall));
  endtask

  vec_t vt[8];
  vec_t hv;
  int   we0, rd0;

  initial begin
    //        rw    mt     mw    mr    ut    rdata          alu            rd  pc  rxv   rxd    stl we    data
    vt[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 5,  0, 1'b1, 8'hEE, 0, 1'b0, 32'h1234_5678};
    vt[1] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0010, 0,  0, 1'b1, 8'hEE, 0, 1'b1, 32'h0000_0010};
    vt[2] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0010, 7,  0, 1'b1, 8'hEE, L, 1'b0, 32'hDEAD_BEEF};
    vt[3] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_FFFF, 31, 3, 1'b0, 8'h00, 0, 1'b0, 32'h0000_0003};
    vt[4] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_0001, 2,  1, 1'b0, 8'h00, 0, 1'b0, 32'hCAFE_F00D};
    vt[5] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0077, 9,  0, 1'b1, 8'h5A, 0, 1'b0, 32'h0000_005A};
    vt[6] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0020, 3,  0, 1'b0, 8'h00, L, 1'b0, 32'hA500_0020};
    vt[7] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0021, 4,  0, 1'b0, 8'h00, L, 1'b0, 32'hA500_0021};

    reset = 1'b1; in_valid = 1'b0; RegWrite = 1'b0; MemtoReg = 2'b00; MemWrite = 1'b0;
    MemRead = 1'b0; UARTtoReg = 1'b0; register_data = '0; alu_result = '0; rdist = '0;
    pc1 = '0; uart_rx_valid = 1'b0; uart_rx_data = '0;
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    we0 = we_cnt;
    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("v%0d", i), -1, 8'h00);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bubble_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("bubble_RegWrite_wb", {31'b0, RegWrite_wb}, 32'd0);
    chk("sb_drained_table", 32'(sbq.size()), 32'd0);
    chk("store_we_pulses", 32'(we_cnt - we0), 32'd1);
    @(posedge clk); #1;

    // UART pop with rx_valid low for 4 cycles
    rd0 = ready_cnt;
    hv = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0099, 12, 0, 1'b0, 8'h00, 4, 1'b0, 32'h0000_0041};
    run_vec(hv, "uart_wait", 4, 8'h41);
    in_valid = 1'b0; uart_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("uart_ready_pulses", 32'(ready_cnt - rd0), 32'd1);
    chk("sb_drained_uart", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;

    // Reset while waiting on a load
    drive(vt[6]);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("midrst_RegWrite_wb", {31'b0, RegWrite_wb}, 32'd0);
    chk("midrst_rdist_wb", {27'b0, rdist_wb}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    chk("midrst_we", {31'b0, dmem_we}, 32'd0);
    chk("midrst_ready", {31'b0, uart_rx_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("postrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("postrst_stall", {31'b0, stall}, 32'd0);
    chk("postrst_dmem_addr", {16'b0, dmem_addr}, {16'b0, alu_result[15:0]});

    // Plain op after the abandoned load goes straight through
    @(posedge clk); #1;
    run_vec(vt[0], "after_rst", -1, 8'h00);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained_final", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
